// File: rtl/card_shoe_if.sv
// Card shoe request/deal bundle between the shoe and its consumer.
// Latency: none (wires only).
// Backpressure: none; the consumer waits for card_valid and ignores busy-time requests.
// Ports: draw_req/shuffle flow from the consumer (master) to the shoe (slave);
//   card, card_valid, busy, cards_left and deck_low flow back.
interface card_shoe_if;
  logic       draw_req;
  logic       shuffle;
  logic [3:0] card;
  logic       card_valid;
  logic       busy;
  logic [5:0] cards_left;
  logic       deck_low;

  modport master (
    output draw_req, shuffle,
    input  card, card_valid, busy, cards_left, deck_low
  );

  modport slave (
    input  draw_req, shuffle,
    output card, card_valid, busy, cards_left, deck_low
  );
endinterface

// File: rtl/card_shoe.sv
// 52-card shoe: deals ranks 1..13 without repetition until reshuffled.
// Latency: 3+k cycles from accepted draw_req to card_valid (k = occupied slots probed), +1 if a shuffle precedes.
// Backpressure: draw_req/shuffle are sampled only in IDLE; busy is high otherwise.
// Ports: clk, resetn (synchronous, active-low); sh (slave) carries draw_req, shuffle,
//   card, card_valid, busy, cards_left, deck_low.
module card_shoe #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          LOW_MARK  = 10
) (
  input  logic        clk,
  input  logic        resetn,
  card_shoe_if.slave  sh
);

  typedef enum logic [2:0] {IDLE, SHUF, PICK, PROBE, DEAL} state_t;

  localparam logic [5:0] LOW_MARK_6 = 6'(LOW_MARK);

  state_t      state, state_nxt;
  logic [51:0] used;
  logic [5:0]  idx;
  logic [5:0]  cards_left_q;
  logic [3:0]  card_q;
  logic        card_valid_q;
  logic        pending_draw;
  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [5:0]  pick_idx;

  // Taps 16,14,13,11; a nonzero seed keeps the register out of the all-zero lockup state.
  assign lfsr_fb  = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
  // Fold 52..63 back onto 0..11 so every sample lands on a real card index.
  assign pick_idx = (lfsr[5:0] >= 6'd52) ? (lfsr[5:0] - 6'd52) : lfsr[5:0];

  function automatic logic [3:0] rank_of(input logic [5:0] i);
    logic [5:0] r;
    if (i >= 6'd39)      r = i - 6'd39;
    else if (i >= 6'd26) r = i - 6'd26;
    else if (i >= 6'd13) r = i - 6'd13;
    else                 r = i;
    return r[3:0] + 4'd1;
  endfunction

  // State register
  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (sh.shuffle)
          state_nxt = SHUF;
        else if (sh.draw_req)
          state_nxt = (cards_left_q == 6'd0) ? SHUF : PICK;
      end
      SHUF:    state_nxt = pending_draw ? PICK : IDLE;
      PICK:    state_nxt = PROBE;
      PROBE:   if (!used[idx]) state_nxt = DEAL;
      DEAL:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath
  always_ff @(posedge clk) begin
    if (!resetn) begin
      lfsr         <= LFSR_SEED;
      used         <= '0;
      cards_left_q <= 6'd52;
      card_q       <= 4'd0;
      card_valid_q <= 1'b0;
      pending_draw <= 1'b0;
      idx          <= 6'd0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr_fb};
      // Strobe lands in the IDLE cycle right after DEAL.
      card_valid_q <= (state == DEAL);
      case (state)
        IDLE: begin
          if (sh.shuffle)
            pending_draw <= sh.draw_req;
          else if (sh.draw_req && cards_left_q == 6'd0)
            pending_draw <= 1'b1;
        end
        SHUF: begin
          used         <= '0;
          cards_left_q <= 6'd52;
          pending_draw <= 1'b0;
        end
        PICK: idx <= pick_idx;
        PROBE: begin
          // Linear probe with wrap; a free slot exists whenever cards_left > 0.
          if (used[idx])
            idx <= (idx == 6'd51) ? 6'd0 : idx + 6'd1;
        end
        DEAL: begin
          used[idx]    <= 1'b1;
          cards_left_q <= cards_left_q - 6'd1;
          card_q       <= rank_of(idx);
        end
        default: ;
      endcase
    end
  end

  // Outputs
  always_comb begin
    sh.busy = (state != IDLE);
  end

  assign sh.card       = card_q;
  assign sh.card_valid = card_valid_q;
  assign sh.cards_left = cards_left_q;
  assign sh.deck_low   = (cards_left_q < LOW_MARK_6);

endmodule

// File: tb/tb_card_shoe.sv
// Directed bench for card_shoe with a scoreboard of expected deals.
// Latency: n/a.
// Backpressure: n/a.
module tb_card_shoe;

  localparam logic [15:0] SEED = 16'hACE1;

  typedef struct {
    logic [3:0] card;
    int         lat;
    int         left;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  card_shoe_if sh();

  card_shoe #(.LFSR_SEED(SEED), .LOW_MARK(10)) dut (
    .clk    (clk),
    .resetn (resetn),
    .sh     (sh)
  );

  int   tests = 0;
  int   fails = 0;
  int   n_adv = 0;
  exp_t q[$];
  bit   mdl_used[52];
  int   mdl_left;
  int   rank_cnt[16];

  // Number of LFSR advances since the last reset edge.
  always @(posedge clk) begin
    if (!resetn) n_adv <= 0;
    else         n_adv <= n_adv + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] lfsr_at(input int m);
    logic [15:0] l;
    l = SEED;
    for (int i = 0; i < m; i++) l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction

  task automatic mdl_reset();
    foreach (mdl_used[i]) mdl_used[i] = 1'b0;
    mdl_left = 52;
  endtask

  task automatic do_draw(input bit with_shuf);
    exp_t        e;
    int          extra, idx, k, lat;
    logic [15:0] v;
    bit          got, busy_ok;
    @(negedge clk);
    sh.draw_req = 1'b1;
    sh.shuffle  = with_shuf;
    extra = (with_shuf || mdl_left == 0) ? 1 : 0;
    if (extra == 1) mdl_reset();
    v   = lfsr_at(n_adv + 1 + extra);
    idx = int'(v[5:0]);
    if (idx >= 52) idx -= 52;
    k = 0;
    while (mdl_used[idx]) begin
      idx = (idx == 51) ? 0 : idx + 1;
      k++;
    end
    mdl_used[idx] = 1'b1;
    mdl_left--;
    e.card = 4'(idx % 13 + 1);
    e.lat  = 3 + extra + k;
    e.left = mdl_left;
    q.push_back(e);
    @(posedge clk); #1;
    sh.draw_req = 1'b0;
    sh.shuffle  = 1'b0;
    lat = 0; got = 1'b0; busy_ok = 1'b1;
    while (!got && lat < 80) begin
      @(posedge clk); #1;
      lat++;
      if (sh.card_valid) got = 1'b1;
      else begin
        if (!sh.busy) busy_ok = 1'b0;
        if (extra == 1 && lat == 1) chk("shuf_cards_left", 32'(sh.cards_left), 32'd52);
      end
    end
    chk("busy_while_dealing", 32'(busy_ok), 32'd1);
    chk("strobe_seen", 32'(got), 32'd1);
    if (got) begin
      chk("q_depth", 32'(q.size()), 32'd1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("card", 32'(sh.card), 32'(e.card));
        chk("latency", 32'(lat), 32'(e.lat));
        chk("cards_left", 32'(sh.cards_left), 32'(e.left));
        chk("deck_low", 32'(sh.deck_low), 32'(e.left < 10));
        chk("busy_at_strobe", 32'(sh.busy), 32'd0);
      end
      rank_cnt[sh.card]++;
      @(posedge clk); #1;
      chk("strobe_width", 32'(sh.card_valid), 32'd0);
      chk("card_held", 32'(sh.card), 32'(e.card));
    end
  endtask

  initial begin
    int seen;
    sh.draw_req = 1'b0;
    sh.shuffle  = 1'b0;
    mdl_reset();
    foreach (rank_cnt[i]) rank_cnt[i] = 0;
    resetn = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) resetn = 1'b1;

    // Idle after reset
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      seen += int'(sh.card_valid);
    end
    chk("idle_no_strobe", 32'(seen), 32'd0);
    chk("rst_card", 32'(sh.card), 32'd0);
    chk("rst_busy", 32'(sh.busy), 32'd0);
    chk("rst_cards_left", 32'(sh.cards_left), 32'd52);
    chk("rst_deck_low", 32'(sh.deck_low), 32'd0);

    // Whole deck, one card at a time
    for (int d = 0; d < 52; d++) do_draw(1'b0);
    for (int r = 1; r <= 13; r++) chk("rank_count", 32'(rank_cnt[r]), 32'd4);
    chk("empty_cards_left", 32'(sh.cards_left), 32'd0);
    chk("empty_deck_low", 32'(sh.deck_low), 32'd1);

    // Draw from an empty shoe reshuffles automatically
    do_draw(1'b0);
    chk("auto_reshuf_left", 32'(sh.cards_left), 32'd51);

    // 20 draws into the new deck, then shuffle + draw together
    for (int d = 0; d < 19; d++) do_draw(1'b0);
    chk("twenty_dealt", 32'(sh.cards_left), 32'd32);
    do_draw(1'b1);
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      seen += int'(sh.card_valid);
    end
    chk("single_strobe", 32'(seen), 32'd0);

    // Reset mid-PROBE with 30 cards left
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) resetn = 1'b1;
    mdl_reset();
    for (int d = 0; d < 22; d++) do_draw(1'b0);
    chk("thirty_left", 32'(sh.cards_left), 32'd30);
    @(negedge clk) sh.draw_req = 1'b1;
    @(posedge clk); #1;
    sh.draw_req = 1'b0;
    @(posedge clk); #1;
    chk("probe_busy", 32'(sh.busy), 32'd1);
    resetn = 1'b0;
    @(posedge clk); #1;
    seen = int'(sh.card_valid);
    @(negedge clk) resetn = 1'b1;
    mdl_reset();
    repeat (10) begin
      @(posedge clk); #1;
      seen += int'(sh.card_valid);
    end
    chk("abort_no_strobe", 32'(seen), 32'd0);
    chk("abort_cards_left", 32'(sh.cards_left), 32'd52);
    chk("abort_card", 32'(sh.card), 32'd0);
    chk("abort_busy", 32'(sh.busy), 32'd0);
    chk("abort_deck_low", 32'(sh.deck_low), 32'd0);
    do_draw(1'b0);
    chk("fresh_left", 32'(sh.cards_left), 32'd51);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
